// File: rtl/riscv_dmem_click_resp_pkg.sv
// riscv_dmem_click_resp_pkg
//   Shared types and constants for the MEM-stage click-network data-memory
//   responder and its request/response interface.
//   Contents:
//     XLEN_DEF  default data/address width
//     STRB_W    number of byte lanes per word
//     state_e   responder FSM state encoding (IDLE / ACCESS / RESP)
//     lane_mask expands a byte-strobe vector into a bit mask
package riscv_dmem_click_resp_pkg;

  localparam int XLEN_DEF = 32;
  localparam int STRB_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  function automatic logic [STRB_W*8-1:0] lane_mask(input logic [STRB_W-1:0] strb);
    logic [STRB_W*8-1:0] m;
    m = '0;
    for (int i = 0; i < STRB_W; i++) begin
      m[i*8 +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/riscv_dmem_click_resp_if.sv
// riscv_dmem_click_resp_if
//   Bundled-data port between the asynchronous MEM stage (master) and the
//   synchronous data-memory responder (slave).
//   Signals:
//     i_req      2-phase request toggle (asynchronous to the responder clock)
//     i_addr     byte address, bundled with i_req
//     i_wr_en    1 = write, 0 = read, bundled
//     i_strb     byte write strobes, bundled
//     i_wr_data  write data, bundled
//     o_ack      2-phase acknowledge toggle
//     o_rd_data  read data, valid from an o_ack toggle until the next one
//     o_busy     responder has a transaction in flight
//     o_err      last transaction was out of range or misaligned
interface riscv_dmem_click_resp_if #(
  parameter int XLEN = 32
);
  import riscv_dmem_click_resp_pkg::*;

  logic              i_req;
  logic [XLEN-1:0]   i_addr;
  logic              i_wr_en;
  logic [STRB_W-1:0] i_strb;
  logic [XLEN-1:0]   i_wr_data;
  logic              o_ack;
  logic [XLEN-1:0]   o_rd_data;
  logic              o_busy;
  logic              o_err;

  modport master (
    output i_req,
    output i_addr,
    output i_wr_en,
    output i_strb,
    output i_wr_data,
    input  o_ack,
    input  o_rd_data,
    input  o_busy,
    input  o_err
  );

  modport slave (
    input  i_req,
    input  i_addr,
    input  i_wr_en,
    input  i_strb,
    input  i_wr_data,
    output o_ack,
    output o_rd_data,
    output o_busy,
    output o_err
  );

endinterface

// File: rtl/riscv_sync_toggle.sv
// riscv_sync_toggle
//   N-flop synchronizer for a 2-phase toggle crossing into the i_clk domain.
//   Shared by the data- and instruction-memory responders.
//   Ports:
//     i_clk  clock
//     i_rst  synchronous active-high reset, clears every stage to 0
//     i_d    asynchronous input level
//     o_q    synchronized level (last stage)
module riscv_sync_toggle #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/riscv_dmem_click_resp.sv
// riscv_dmem_click_resp
//   Synchronous data-memory responder for the asynchronous pipeline's MEM
//   stage. A change of the synchronized request level relative to the last
//   served phase starts a transaction: the bundle is captured, a byte-strobed
//   write or a word read is performed on the internal array, and o_ack is
//   toggled with the read data (0 for writes) and the error flag.
//   Ports:
//     i_clk  clock
//     i_rst  synchronous active-high reset (array contents are kept)
//     bus    slave side of riscv_dmem_click_resp_if
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for req_s to differ from the served phase
//   ST_ACCESS | array access; write commits / read launches on first edge,
//             | then cnt counts down RD_LAT-1 .. 0
//   ST_RESP   | drive read data and error, toggle ack, record served phase
module riscv_dmem_click_resp
  import riscv_dmem_click_resp_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int DEPTH_WORDS = 1024,
  parameter int SYNC_STAGES = 2,
  parameter int RD_LAT      = 1
) (
  input logic                    i_clk,
  input logic                    i_rst,
  riscv_dmem_click_resp_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(RD_LAT - 1);

  state_e state_q, state_d;

  logic req_s;
  logic served_q;
  logic pending;

  logic capture;
  logic do_access;
  logic do_resp;

  logic [CW-1:0]     cnt_q;
  logic              first_q;

  logic [AW-1:0]     idx_q;
  logic              wr_q;
  logic [STRB_W-1:0] strb_q;
  logic [XLEN-1:0]   wdata_q;
  logic              oor_q;
  logic              bad_q;

  logic              req_oor;
  logic              req_mis;

  logic [XLEN-1:0]   mem [DEPTH_WORDS];
  logic [XLEN-1:0]   rd_q;

  logic              ack_q;
  logic [XLEN-1:0]   rd_data_q;
  logic              err_q;

  riscv_sync_toggle #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (bus.i_req),
    .o_q   (req_s)
  );

  assign pending = req_s != served_q;

  // Bundle is only looked at while capturing, by which time the
  // synchronizer delay guarantees it has settled.
  assign req_oor = |bus.i_addr[XLEN-1:AW+2];
  assign req_mis = bus.i_wr_en && (bus.i_strb == '1) && (bus.i_addr[1:0] != 2'b00);

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    do_access = 1'b0;
    do_resp   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pending) begin
          capture = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        do_access = first_q;
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        do_resp = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      served_q  <= 1'b0;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      ack_q     <= 1'b0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        cnt_q   <= CNT_INIT;
        first_q <= 1'b1;
      end else if (state_q == ST_ACCESS) begin
        first_q <= 1'b0;
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
      if (do_resp) begin
        rd_data_q <= wr_q ? '0 : rd_q;
        err_q     <= bad_q;
        ack_q     <= ~ack_q;
        served_q  <= req_s;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (capture) begin
      idx_q   <= bus.i_addr[AW+1:2];
      wr_q    <= bus.i_wr_en;
      strb_q  <= bus.i_strb;
      wdata_q <= bus.i_wr_data;
      oor_q   <= req_oor;
      bad_q   <= req_oor || req_mis;
    end
  end

  // Reset on the first ACCESS edge must abandon the write, hence the
  // explicit i_rst gate on a block that otherwise has no reset.
  always_ff @(posedge i_clk) begin
    if (do_access && !i_rst) begin
      if (wr_q && !bad_q) begin
        mem[idx_q] <= (mem[idx_q] & ~lane_mask(strb_q)) | (wdata_q & lane_mask(strb_q));
      end
      rd_q <= oor_q ? '0 : mem[idx_q];
    end
  end

  assign bus.o_ack     = ack_q;
  assign bus.o_rd_data = rd_data_q;
  assign bus.o_err     = err_q;
  assign bus.o_busy    = state_q != ST_IDLE;

endmodule

// File: tb/tb_riscv_dmem_click_resp.sv
module tb_riscv_dmem_click_resp;

  logic i_clk = 1'b0;
  logic i_rst;

  always #5 i_clk = ~i_clk;

  riscv_dmem_click_resp_if #(.XLEN(32)) bus1 ();
  riscv_dmem_click_resp_if #(.XLEN(32)) bus3 ();

  riscv_dmem_click_resp #(
    .XLEN(32), .DEPTH_WORDS(1024), .SYNC_STAGES(2), .RD_LAT(1)
  ) dut1 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus1)
  );

  riscv_dmem_click_resp #(
    .XLEN(32), .DEPTH_WORDS(1024), .SYNC_STAGES(2), .RD_LAT(3)
  ) dut3 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference memories, one per DUT, keyed by word index
  logic [31:0] m1 [int];
  logic [31:0] m3 [int];

  // Behavioural model: what a transaction should return and how it changes memory.
  function automatic void model_txn(input int sel, input logic [31:0] addr, input logic wr,
                                    input logic [3:0] strb, input logic [31:0] wd,
                                    output logic [31:0] rd, output logic err);
    int unsigned widx;
    logic oor, mis;
    logic [31:0] w;
    widx = addr >> 2;
    oor  = widx >= 1024;
    mis  = wr && (strb == 4'hF) && (addr % 4 != 0);
    err  = oor || mis;
    rd   = 32'h0;
    if (wr) begin
      if (!err) begin
        w = (sel == 1) ? m1[widx] : m3[widx];
        for (int i = 0; i < 4; i++) if (strb[i]) w[i*8 +: 8] = wd[i*8 +: 8];
        if (sel == 1) m1[widx] = w; else m3[widx] = w;
      end
    end else if (!oor) begin
      rd = (sel == 1) ? m1[widx] : m3[widx];
    end
  endfunction

  // Requester: issue one 2-phase transaction and wait (bounded) for the ack toggle.
  // lat = edges from the first edge sampling the new req level, -1 on timeout.
  task automatic txn(input int sel, input logic [31:0] addr, input logic wr,
                     input logic [3:0] strb, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err, output int lat,
                     output logic [63:0] bh);
    logic ack0, ackn;
    @(negedge i_clk);
    if (sel == 1) begin
      bus1.i_addr = addr; bus1.i_wr_en = wr; bus1.i_strb = strb; bus1.i_wr_data = wd;
      bus1.i_req = ~bus1.i_req;
      ack0 = bus1.o_ack;
    end else begin
      bus3.i_addr = addr; bus3.i_wr_en = wr; bus3.i_strb = strb; bus3.i_wr_data = wd;
      bus3.i_req = ~bus3.i_req;
      ack0 = bus3.o_ack;
    end
    lat = -1;
    bh  = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge i_clk); #1;
      bh[k] = (sel == 1) ? bus1.o_busy : bus3.o_busy;
      ackn  = (sel == 1) ? bus1.o_ack : bus3.o_ack;
      if (ackn !== ack0) begin
        lat = k;
        break;
      end
    end
    rd  = (sel == 1) ? bus1.o_rd_data : bus3.o_rd_data;
    err = (sel == 1) ? bus1.o_err : bus3.o_err;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.i_wr_en = 1'b0; bus1.i_strb = '0; bus1.i_wr_data = '0;
    bus3.i_req = 1'b0; bus3.i_addr = '0; bus3.i_wr_en = 1'b0; bus3.i_strb = '0; bus3.i_wr_data = '0;
    repeat (3) @(posedge i_clk);
    #1;
    n_tests++; if ({bus1.o_ack, bus1.o_busy, bus1.o_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags1: got %b expected 000", {bus1.o_ack, bus1.o_busy, bus1.o_err}); end
    n_tests++; if (bus1.o_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd1: got %h expected 0", bus1.o_rd_data); end
    n_tests++; if ({bus3.o_ack, bus3.o_busy, bus3.o_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags3: got %b expected 000", {bus3.o_ack, bus3.o_busy, bus3.o_err}); end
    n_tests++; if (bus3.o_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd3: got %h expected 0", bus3.o_rd_data); end
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic [31:0] rd, erd; logic er, eer; int lat; logic [63:0] bh;
    model_txn(1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, erd, eer);
    txn(1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, rd, er, lat, bh);
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL wr_latency: got %0d expected 5", lat); end
    n_tests++; if (bus1.o_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack_level: got %b expected 1", bus1.o_ack); end
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b expected 0", er); end
    n_tests++; if (rd !== erd) begin n_fail++; $display("FAIL wr_rd_data: got %h expected %h", rd, erd); end
    n_tests++; if ({bh[1], bh[3], bh[4], bh[5]} !== 4'b0110) begin n_fail++; $display("FAIL wr_busy_window: got %b expected 0110", {bh[1], bh[3], bh[4], bh[5]}); end
    model_txn(1, 32'h10, 1'b0, 4'h0, 32'h0, erd, eer);
    txn(1, 32'h10, 1'b0, 4'h0, 32'h0, rd, er, lat, bh);
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL rd_latency: got %0d expected 5", lat); end
    n_tests++; if (bus1.o_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack_level: got %b expected 0", bus1.o_ack); end
    n_tests++; if (rd !== 32'hDEADBEEF || rd !== erd) begin n_fail++; $display("FAIL rd_data: got %h expected DEADBEEF", rd); end
  endtask

  task automatic test_partial_strobe();
    logic [31:0] rd, erd; logic er, eer; int lat; logic [63:0] bh;
    model_txn(1, 32'h10, 1'b1, 4'b0010, 32'h0000AA00, erd, eer);
    txn(1, 32'h10, 1'b1, 4'b0010, 32'h0000AA00, rd, er, lat, bh);
    n_tests++; if (er !== eer || lat !== 5) begin n_fail++; $display("FAIL strb_wr: got err %b lat %0d expected err %b lat 5", er, lat, eer); end
    model_txn(1, 32'h10, 1'b0, 4'h0, 32'h0, erd, eer);
    txn(1, 32'h10, 1'b0, 4'h0, 32'h0, rd, er, lat, bh);
    n_tests++; if (rd !== 32'hDEADAAEF || rd !== erd) begin n_fail++; $display("FAIL strb_rd: got %h expected DEADAAEF", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat; logic [63:0] bh;
    txn(1, 32'h1000, 1'b0, 4'h0, 32'h0, rd, er, lat, bh);
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL oor_rd_latency: got %0d expected 5", lat); end
    n_tests++; if (rd !== 32'h0 || er !== 1'b1) begin n_fail++; $display("FAIL oor_rd: got data %h err %b expected 0 1", rd, er); end
    // 0x1010 aliases word 4 in the low index bits; must not land there
    txn(1, 32'h1010, 1'b1, 4'hF, 32'h55555555, rd, er, lat, bh);
    n_tests++; if (er !== 1'b1 || lat !== 5) begin n_fail++; $display("FAIL oor_wr: got err %b lat %0d expected 1 5", er, lat); end
    txn(1, 32'h10, 1'b0, 4'h0, 32'h0, rd, er, lat, bh);
    n_tests++; if (rd !== 32'hDEADAAEF || er !== 1'b0) begin n_fail++; $display("FAIL oor_clear: got data %h err %b expected DEADAAEF 0", rd, er); end
  endtask

  task automatic test_misaligned_strb0();
    logic [31:0] rd, erd; logic er, eer; int lat; logic [63:0] bh;
    model_txn(1, 32'h12, 1'b1, 4'hF, 32'h11111111, erd, eer);
    txn(1, 32'h12, 1'b1, 4'hF, 32'h11111111, rd, er, lat, bh);
    n_tests++; if (er !== 1'b1 || eer !== 1'b1) begin n_fail++; $display("FAIL mis_wr_err: got %b expected 1", er); end
    model_txn(1, 32'h13, 1'b1, 4'b1000, 32'h77000000, erd, eer);
    txn(1, 32'h13, 1'b1, 4'b1000, 32'h77000000, rd, er, lat, bh);
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL subword_wr_err: got %b expected 0", er); end
    model_txn(1, 32'h10, 1'b1, 4'h0, 32'hFFFFFFFF, erd, eer);
    txn(1, 32'h10, 1'b1, 4'h0, 32'hFFFFFFFF, rd, er, lat, bh);
    n_tests++; if (er !== 1'b0 || lat !== 5) begin n_fail++; $display("FAIL strb0_wr: got err %b lat %0d expected 0 5", er, lat); end
    model_txn(1, 32'h10, 1'b0, 4'h0, 32'h0, erd, eer);
    txn(1, 32'h10, 1'b0, 4'h0, 32'h0, rd, er, lat, bh);
    n_tests++; if (rd !== 32'h77ADAAEF || rd !== erd) begin n_fail++; $display("FAIL mis_rd_back: got %h expected 77ADAAEF", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wd; logic er, eer, wr; logic [3:0] strb; int lat; logic [63:0] bh;
    int idx;
    for (int i = 0; i <= 16; i++) begin
      idx = (i == 16) ? 1023 : i;
      wd = $urandom;
      model_txn(1, idx * 4, 1'b1, 4'hF, wd, erd, eer);
      txn(1, idx * 4, 1'b1, 4'hF, wd, rd, er, lat, bh);
    end
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        addr = 32'h1000 + $urandom_range(0, 32'h7FFF);
      end else begin
        idx  = ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 15);
        addr = idx * 4 + $urandom_range(0, 3);
      end
      wr   = 1'($urandom_range(0, 1));
      strb = 4'($urandom_range(0, 15));
      wd   = $urandom;
      model_txn(1, addr, wr, strb, wd, erd, eer);
      txn(1, addr, wr, strb, wd, rd, er, lat, bh);
      n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected 5", n, lat); end
      n_tests++; if (rd !== erd) begin n_fail++; $display("FAIL rand_data[%0d] addr %h wr %b: got %h expected %h", n, addr, wr, rd, erd); end
      n_tests++; if (er !== eer) begin n_fail++; $display("FAIL rand_err[%0d] addr %h: got %b expected %b", n, addr, er, eer); end
    end
  endtask

  task automatic test_reset_mid_txn();
    logic [31:0] rd, erd; logic er, eer; int lat; logic [63:0] bh;
    model_txn(1, 32'h20, 1'b1, 4'hF, 32'hCAFEF00D, erd, eer);
    txn(1, 32'h20, 1'b1, 4'hF, 32'hCAFEF00D, rd, er, lat, bh);
    @(negedge i_clk);
    bus1.i_addr = 32'h20; bus1.i_wr_en = 1'b1; bus1.i_strb = 4'hF; bus1.i_wr_data = 32'h12345678;
    bus1.i_req = ~bus1.i_req;
    repeat (3) @(posedge i_clk);
    #1;
    n_tests++; if (bus1.o_busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_access: got busy %b expected 1", bus1.o_busy); end
    i_rst = 1'b1;
    bus1.i_req = 1'b0;
    bus3.i_req = 1'b0;
    @(posedge i_clk); #1;
    n_tests++; if (bus1.o_ack !== 1'b0 || bus1.o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_abandon: got ack %b busy %b expected 0 0", bus1.o_ack, bus1.o_busy); end
    @(negedge i_clk);
    i_rst = 1'b0;
    model_txn(1, 32'h20, 1'b0, 4'h0, 32'h0, erd, eer);
    txn(1, 32'h20, 1'b0, 4'h0, 32'h0, rd, er, lat, bh);
    n_tests++; if (rd !== 32'hCAFEF00D || rd !== erd || lat !== 5) begin n_fail++; $display("FAIL rstmid_suppressed: got %h lat %0d expected CAFEF00D lat 5", rd, lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd, wd; logic er, eer; int lat; logic [63:0] bh;
    int n_req;
    n_req = 0;
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      model_txn(3, i * 4, 1'b1, 4'hF, wd, erd, eer);
      txn(3, i * 4, 1'b1, 4'hF, wd, rd, er, lat, bh);
      n_req++;
      n_tests++; if (lat !== 7) begin n_fail++; $display("FAIL b2b_wr_latency[%0d]: got %0d expected 7", i, lat); end
    end
    for (int i = 0; i < 8; i++) begin
      model_txn(3, (7 - i) * 4, 1'b0, 4'h0, 32'h0, erd, eer);
      txn(3, (7 - i) * 4, 1'b0, 4'h0, 32'h0, rd, er, lat, bh);
      n_req++;
      n_tests++; if (lat !== 7) begin n_fail++; $display("FAIL b2b_rd_latency[%0d]: got %0d expected 7", i, lat); end
      n_tests++; if (rd !== erd || er !== 1'b0) begin n_fail++; $display("FAIL b2b_rd_data[%0d]: got %h err %b expected %h 0", i, rd, er, erd); end
    end
    n_tests++; if (bus3.o_ack !== 1'(n_req % 2)) begin n_fail++; $display("FAIL b2b_ack_parity: got %b expected %0d", bus3.o_ack, n_req % 2); end
  endtask

  initial begin
    i_rst = 1'b1;
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_out_of_range();
    test_misaligned_strb0();
    test_random();
    test_reset_mid_txn();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
